// File: rtl/servo_pkg.sv
// Shared timing defaults and helpers for the multi-channel servo PWM block.
package servo_pkg;

  localparam int CLK_HZ   = 50_000_000;
  localparam int TICK_HZ  = 1_000_000;
  localparam int FRAME_US = 20_000;
  localparam int MIN_US   = 1_000;
  localparam int MAX_US   = 2_000;

  // Power-up / reset pulse width: midpoint of the legal range.
  function automatic int mid_us(input int lo, input int hi);
    return (lo + hi) / 2;
  endfunction

  // Unsigned clamp; callers zero-extend narrower positions to 32 bits.
  function automatic logic [31:0] clamp_pos(input logic [31:0] pos,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    if (pos < lo) return lo;
    if (pos > hi) return hi;
    return pos;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Prescaler: divides mclk down to a one-cycle tick enable every DIV cycles.
module servo_tick_gen
  import servo_pkg::*;
#(
  parameter int DIV = CLK_HZ / TICK_HZ
) (
  input  logic mclk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/multi_servo_pwm.sv
// N-channel servo PWM generator with shadowed pulse widths committed at each frame boundary.
// Optional build macro SLEW_LIMIT_EN limits each commit to a SLEW_US step toward the shadow value.
module multi_servo_pwm
  import servo_pkg::*;
#(
  parameter int CLK_HZ   = servo_pkg::CLK_HZ,
  parameter int TICK_HZ  = servo_pkg::TICK_HZ,
  parameter int N_CH     = 4,
  parameter int FRAME_US = servo_pkg::FRAME_US,
  parameter int MIN_US   = servo_pkg::MIN_US,
  parameter int MAX_US   = servo_pkg::MAX_US,
  parameter int W        = 16,
  parameter int SLEW_US  = 50,
  localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            mclk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_ch,
  input  logic [W-1:0]    wr_pos,
  input  logic [CW-1:0]   rd_ch,
  output logic [W-1:0]    rd_pos,
  output logic            wr_err,
  output logic            frame_strobe,
  output logic [N_CH-1:0] pwm
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [W-1:0] MID        = W'(mid_us(MIN_US, MAX_US));
  localparam logic [W-1:0] FRAME_LAST = W'(FRAME_US - 1);
  localparam logic [CW:0]  N_CH_W     = (CW + 1)'(N_CH);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2 || MIN_US >= MAX_US || MAX_US >= FRAME_US ||
      SLEW_US < 1 || N_CH < 1 || N_CH > 16 || ((FRAME_US - 1) >> W) != 0) begin : g_bad_cfg
    $error("multi_servo_pwm: inconsistent timing parameters");
  end

  logic                   tick;
  logic                   commit;
  logic                   wr_ok;
  logic [W-1:0]           wr_pos_clamped;
  logic [W-1:0]           frame_cnt_reg;
  logic [N_CH-1:0][W-1:0] active_vec;
  logic [N_CH-1:0]        pwm_next;
  logic [N_CH-1:0]        pwm_reg;
  logic [W-1:0]           rd_next;
  logic [W-1:0]           rd_pos_reg;
  logic                   wr_err_reg;
  logic                   frame_strobe_reg;

  servo_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .mclk  (mclk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign commit         = tick && (frame_cnt_reg == FRAME_LAST);
  assign wr_ok          = wr_en && ({1'b0, wr_ch} < N_CH_W);
  assign wr_pos_clamped = W'(clamp_pos(32'(wr_pos), 32'(MIN_US), 32'(MAX_US)));

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic         wr_hit;
    logic [W-1:0] shadow_reg;
    logic [W-1:0] active_reg;
    logic [W-1:0] commit_val;

    assign wr_hit = wr_ok && (wr_ch == CW'(gi));

`ifdef SLEW_LIMIT_EN
    localparam logic [W:0]   SLEW_X = (W + 1)'(SLEW_US);
    localparam logic [W-1:0] SLEW_N = W'(SLEW_US);
    logic [W:0] diff_up;
    logic [W:0] diff_dn;

    // Differences are taken one bit wider so the comparison never sees a wrapped value;
    // the stepped result always lies between active and shadow, so W bits hold it.
    always_comb begin
      diff_up = {1'b0, shadow_reg} - {1'b0, active_reg};
      diff_dn = {1'b0, active_reg} - {1'b0, shadow_reg};
      if (shadow_reg >= active_reg) begin
        commit_val = (diff_up <= SLEW_X) ? shadow_reg : active_reg + SLEW_N;
      end else begin
        commit_val = (diff_dn <= SLEW_X) ? shadow_reg : active_reg - SLEW_N;
      end
    end
`else
    assign commit_val = shadow_reg;
`endif

    // Commit samples the pre-write shadow, so a write in the commit cycle lands next frame.
    always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_reg <= MID;
        active_reg <= MID;
      end else begin
        if (commit) active_reg <= commit_val;
        if (wr_hit) shadow_reg <= wr_pos_clamped;
      end
    end

    assign active_vec[gi] = active_reg;
    assign pwm_next[gi]   = (frame_cnt_reg < active_reg);
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CW'(i)) rd_next = active_vec[i];
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg    <= '0;
      pwm_reg          <= '0;
      rd_pos_reg       <= '0;
      wr_err_reg       <= 1'b0;
      frame_strobe_reg <= 1'b0;
    end else begin
      if (tick) frame_cnt_reg <= commit ? '0 : frame_cnt_reg + 1'b1;
      pwm_reg          <= pwm_next;
      rd_pos_reg       <= rd_next;
      wr_err_reg       <= wr_en && !wr_ok;
      frame_strobe_reg <= commit;
    end
  end

  assign pwm          = pwm_reg;
  assign rd_pos       = rd_pos_reg;
  assign wr_err       = wr_err_reg;
  assign frame_strobe = frame_strobe_reg;

endmodule

// File: tb/tb_multi_servo_pwm.sv
// Scoreboard bench for multi_servo_pwm: a frame-level model predicts pulse widths, readbacks,
// write errors and frame strobes; a monitor measures the DUT and compares. Honours SLEW_LIMIT_EN.
module tb_multi_servo_pwm;

  localparam int CLK_HZ    = 4;
  localparam int TICK_HZ   = 2;
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int N_CH      = 6;
  localparam int CW        = 3;
  localparam int FRAME_US  = 200;
  localparam int MIN_US    = 40;
  localparam int MAX_US    = 120;
  localparam int W         = 16;
  localparam int SLEW_US   = 10;
  localparam int MID       = (MIN_US + MAX_US) / 2;
  localparam int FRAME_CYC = FRAME_US * DIV;

  logic            mclk   = 1'b0;
  logic            rst_n  = 1'b0;
  logic            wr_en  = 1'b0;
  logic [CW-1:0]   wr_ch  = '0;
  logic [W-1:0]    wr_pos = '0;
  logic [CW-1:0]   rd_ch  = '0;
  logic            rd_req = 1'b0;
  logic [W-1:0]    rd_pos;
  logic            wr_err;
  logic            frame_strobe;
  logic [N_CH-1:0] pwm;

  int tests = 0;
  int fails = 0;

  always #5 mclk = ~mclk;

  multi_servo_pwm #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .N_CH     (N_CH),
    .FRAME_US (FRAME_US),
    .MIN_US   (MIN_US),
    .MAX_US   (MAX_US),
    .W        (W),
    .SLEW_US  (SLEW_US)
  ) dut (
    .mclk         (mclk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_pos       (wr_pos),
    .rd_ch        (rd_ch),
    .rd_pos       (rd_pos),
    .wr_err       (wr_err),
    .frame_strobe (frame_strobe),
    .pwm          (pwm)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_shadow[N_CH];
  int m_active[N_CH];
  int exp_w[N_CH][$];
  int exp_rd[$];
  int exp_err[$];
  int exp_strobe[$];
  int m_edge;
  bit m_started;

  function automatic int clampi(input int v);
    if (v < MIN_US) return MIN_US;
    if (v > MAX_US) return MAX_US;
    return v;
  endfunction

  function automatic int next_active(input int sh, input int ac);
`ifdef SLEW_LIMIT_EN
    if (sh > ac + SLEW_US) return ac + SLEW_US;
    if (sh < ac - SLEW_US) return ac - SLEW_US;
`endif
    return sh;
  endfunction

  task automatic model_reset();
    m_edge    = 0;
    m_started = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      m_shadow[i] = MID;
      m_active[i] = MID;
      exp_w[i].delete();
    end
    exp_rd.delete();
    exp_err.delete();
    exp_strobe.delete();
  endtask

  // Frames are FRAME_CYC mclk edges long, counted from reset release; widths are ticks * DIV.
  initial begin : model
    model_reset();
    forever begin
      @(posedge mclk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (!m_started) begin
          m_started = 1'b1;
          for (int i = 0; i < N_CH; i++) exp_w[i].push_back(MID * DIV);
        end
        if (rd_req) exp_rd.push_back((rd_ch < N_CH) ? m_active[rd_ch] : 0);
        m_edge++;
        if (m_edge % FRAME_CYC == 0) begin
          for (int i = 0; i < N_CH; i++) begin
            m_active[i] = next_active(m_shadow[i], m_active[i]);
            exp_w[i].push_back(m_active[i] * DIV);
          end
          exp_strobe.push_back(m_edge);
        end
        if (wr_en) begin
          if (wr_ch < N_CH) m_shadow[wr_ch] = clampi(int'(wr_pos));
          else exp_err.push_back(m_edge);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    int  start_c[N_CH];
    bit  prev[N_CH];
    int  ncyc;
    int  last_strobe;
    int  meas;
    int  e;
    ncyc        = 0;
    last_strobe = -1;
    for (int i = 0; i < N_CH; i++) begin
      prev[i]    = 1'b0;
      start_c[i] = 0;
    end
    forever begin
      @(negedge mclk);
      ncyc++;
      if (!rst_n) begin
        for (int i = 0; i < N_CH; i++) prev[i] = 1'b0;
        last_strobe = -1;
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (pwm[i] && !prev[i]) begin
            start_c[i] = ncyc;
          end else if (!pwm[i] && prev[i]) begin
            meas = ncyc - start_c[i];
            if (exp_w[i].size() == 0) begin
              check($sformatf("pwm%0d_unexpected_pulse", i), meas, 0);
            end else begin
              e = exp_w[i].pop_front();
              check($sformatf("pwm%0d_width", i), meas, e);
              $display("[TB] ch%0d pulse width %0d cycles (expected %0d)", i, meas, e);
            end
          end
          prev[i] = pwm[i];
        end
        if (frame_strobe) begin
          if (exp_strobe.size() == 0) begin
            check("frame_strobe_unexpected", 1, 0);
          end else begin
            e = exp_strobe.pop_front();
            if (last_strobe >= 0) check("frame_strobe_period", ncyc - last_strobe, FRAME_CYC);
            $display("[TB] frame_strobe for commit at edge %0d", e);
          end
          last_strobe = ncyc;
        end
        if (wr_err) begin
          if (exp_err.size() == 0) begin
            check("wr_err_unexpected", 1, 0);
          end else begin
            e = exp_err.pop_front();
            check("wr_err_pulse", int'(wr_err), 1);
            $display("[TB] wr_err for bad write at edge %0d", e);
          end
        end
        while (exp_rd.size() > 0) begin
          e = exp_rd.pop_front();
          check("rd_pos", int'(rd_pos), e);
          $display("[TB] readback rd_pos=%0d (expected %0d)", rd_pos, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic wr(input int ch, input int pos);
    wr_en  = 1'b1;
    wr_ch  = CW'(ch);
    wr_pos = W'(pos);
    @(negedge mclk);
    wr_en  = 1'b0;
  endtask

  task automatic rd(input int ch);
    rd_ch  = CW'(ch);
    rd_req = 1'b1;
    @(negedge mclk);
    rd_req = 1'b0;
  endtask

  // Returns at the negedge just before rising edge number e (edges counted from release).
  task automatic wait_edge(input int e);
    while (m_edge < e - 1) @(negedge mclk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r;
    cyc(3);
    check("reset_pwm", int'(pwm), 0);
    check("reset_rd_pos", int'(rd_pos), 0);
    check("reset_wr_err", int'(wr_err), 0);
    check("reset_frame_strobe", int'(frame_strobe), 0);
    rst_n = 1'b1;
    cyc(5);

    for (int ch = 0; ch < 8; ch++) rd(ch);

    // Mid-frame write only takes effect at the next commit.
    wait_edge(200);
    wr(2, 100);
    wait_edge(600);
    wr(0, 10);
    wr(1, 250);
    wr(7, 50);
    wr(6, 60);
    rd(0);
    rd(1);
    wait_edge(850);
    rd(0);
    rd(1);
    rd(2);

    // Write exactly in the commit cycle of the frame boundary at edge 1200.
    wait_edge(1200);
    wr(3, 60);
    wait_edge(1300);
    wr(4, 50);
    wr(4, 110);
    wait_edge(1700);
    rd(3);
    rd(4);

    for (int c = 0; c < 25 * FRAME_CYC; c++) begin
      r = $urandom_range(0, 99);
      if (r < 3) wr($urandom_range(0, 7), $urandom_range(0, 255));
      else if (r < 6) rd($urandom_range(0, 7));
      else cyc(1);
    end

    // Reset in the middle of a pulse: outputs must drop without waiting for a clock.
    while ((m_edge % FRAME_CYC) != 50) @(negedge mclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm), 0);
    check("async_reset_strobe", int'(frame_strobe), 0);
    check("async_reset_rd_pos", int'(rd_pos), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    rd(2);
    rd(5);
    cyc(FRAME_CYC / 2);

    @(negedge mclk);
    #1;
    for (int i = 0; i < N_CH; i++) check($sformatf("pwm%0d_missing_pulses", i), exp_w[i].size(), 0);
    check("wr_err_missing", exp_err.size(), 0);
    check("frame_strobe_missing", exp_strobe.size(), 0);
    check("rd_pos_pending", exp_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
